// File: rtl/fsk_pkg.sv
// Shared widths, constants and state encoding for the FSK modulator.
package fsk_pkg;
    localparam int SAMPLE_W  = 8;
    localparam int PHASE_W   = 9;
    localparam int PHASE_MOD = 360;
    localparam int AMPLITUDE = 100;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/fsk_modulator_sine_lut.sv
// Degrees-to-sample sine lookup: 91-entry quarter-wave table folded over four quadrants.
module sine_lut
    import fsk_pkg::*;
(
    input  logic [PHASE_W-1:0]  phase_i,
    output logic [SAMPLE_W-1:0] sample_o
);
    logic [6:0] idx;
    logic [6:0] mag;
    logic       neg;

    function automatic logic [6:0] quarter(input logic [6:0] d);
        logic [6:0] q;
        q = 7'd100;
        case (d)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd2;   7'd2:  q = 7'd3;   7'd3:  q = 7'd5;
            7'd4:  q = 7'd7;   7'd5:  q = 7'd9;   7'd6:  q = 7'd10;  7'd7:  q = 7'd12;
            7'd8:  q = 7'd14;  7'd9:  q = 7'd16;  7'd10: q = 7'd17;  7'd11: q = 7'd19;
            7'd12: q = 7'd21;  7'd13: q = 7'd22;  7'd14: q = 7'd24;  7'd15: q = 7'd26;
            7'd16: q = 7'd28;  7'd17: q = 7'd29;  7'd18: q = 7'd31;  7'd19: q = 7'd33;
            7'd20: q = 7'd34;  7'd21: q = 7'd36;  7'd22: q = 7'd37;  7'd23: q = 7'd39;
            7'd24: q = 7'd41;  7'd25: q = 7'd42;  7'd26: q = 7'd44;  7'd27: q = 7'd45;
            7'd28: q = 7'd47;  7'd29: q = 7'd48;  7'd30: q = 7'd50;  7'd31: q = 7'd52;
            7'd32: q = 7'd53;  7'd33: q = 7'd54;  7'd34: q = 7'd56;  7'd35: q = 7'd57;
            7'd36: q = 7'd59;  7'd37: q = 7'd60;  7'd38: q = 7'd62;  7'd39: q = 7'd63;
            7'd40: q = 7'd64;  7'd41: q = 7'd66;  7'd42: q = 7'd67;  7'd43: q = 7'd68;
            7'd44: q = 7'd69;  7'd45: q = 7'd71;  7'd46: q = 7'd72;  7'd47: q = 7'd73;
            7'd48: q = 7'd74;  7'd49: q = 7'd75;  7'd50: q = 7'd77;  7'd51: q = 7'd78;
            7'd52: q = 7'd79;  7'd53: q = 7'd80;  7'd54: q = 7'd81;  7'd55: q = 7'd82;
            7'd56: q = 7'd83;  7'd57: q = 7'd84;  7'd58: q = 7'd85;  7'd59: q = 7'd86;
            7'd60: q = 7'd87;  7'd61: q = 7'd87;  7'd62: q = 7'd88;  7'd63: q = 7'd89;
            7'd64: q = 7'd90;  7'd65: q = 7'd91;  7'd66: q = 7'd91;  7'd67: q = 7'd92;
            7'd68: q = 7'd93;  7'd69: q = 7'd93;  7'd70: q = 7'd94;  7'd71: q = 7'd95;
            7'd72: q = 7'd95;  7'd73: q = 7'd96;  7'd74: q = 7'd96;  7'd75: q = 7'd97;
            7'd76: q = 7'd97;  7'd77: q = 7'd97;  7'd78: q = 7'd98;  7'd79: q = 7'd98;
            7'd80: q = 7'd98;  7'd81: q = 7'd99;  7'd82: q = 7'd99;  7'd83: q = 7'd99;
            7'd84: q = 7'd99;
            default: q = 7'd100;
        endcase
        return q;
    endfunction

    always_comb begin
        idx = '0;
        neg = 1'b0;
        if (phase_i <= 9'd90) begin
            idx = phase_i[6:0];
        end else if (phase_i <= 9'd180) begin
            idx = 7'(9'd180 - phase_i);
        end else if (phase_i <= 9'd270) begin
            idx = 7'(phase_i - 9'd180);
            neg = 1'b1;
        end else begin
            idx = 7'(9'd360 - phase_i);
            neg = 1'b1;
        end
        mag      = quarter(idx);
        sample_o = neg ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    end
endmodule

// File: rtl/fsk_modulator.sv
// Continuous-phase FSK source: one-deep bit holding register feeding a sample
// generator that emits SAMPLES_PER_BIT sine samples per bit, one every SAMPLE_DIV clocks.
//
// state | meaning
// IDLE  | no bit in flight, A and phase held at 0, waiting for a held bit
// SEND  | emitting samples of cur_bit; reloads from hold at bit end when available
module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int SAMPLE_DIV      = 10,
    parameter int SAMPLES_PER_BIT = 360,
    parameter int MARK_STEP       = 2,
    parameter int SPACE_STEP      = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    output logic [SAMPLE_W-1:0] A,
    output logic                sample_strobe,
    output logic                busy
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]   SPB      = CNT_W'(SAMPLES_PER_BIT);
    localparam logic [PHASE_W-1:0] MARK     = PHASE_W'(MARK_STEP);
    localparam logic [PHASE_W-1:0] SPACE    = PHASE_W'(SPACE_STEP);
    localparam logic [PHASE_W:0]   MOD      = (PHASE_W + 1)'(PHASE_MOD);

    state_t              state_q;
    logic                hold_q;
    logic                hold_full_q;
    logic                cur_bit_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [CNT_W-1:0]    sample_cnt_q;
    logic [SAMPLE_W-1:0] a_q;
    logic                strobe_q;

    logic                accept;
    logic                emit;
    logic                bit_end;
    logic [PHASE_W-1:0]  step;
    logic [PHASE_W:0]    phase_sum;
    logic [PHASE_W-1:0]  phase_d;
    logic [DIV_W-1:0]    div_cnt_d;
    logic [CNT_W-1:0]    sample_cnt_d;
    logic [SAMPLE_W-1:0] sine_val;

    sine_lut u_sine (
        .phase_i  (phase_q),
        .sample_o (sine_val)
    );

    assign accept       = bit_valid && !hold_full_q;
    assign emit         = (div_cnt_q == '0);
    assign step         = cur_bit_q ? MARK : SPACE;
    assign phase_sum    = {1'b0, phase_q} + {1'b0, step};
    assign phase_d      = (phase_sum >= MOD) ? PHASE_W'(phase_sum - MOD) : phase_sum[PHASE_W-1:0];
    assign div_cnt_d    = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    assign sample_cnt_d = sample_cnt_q + CNT_W'(emit);
    // With SAMPLE_DIV==1 the last sample and the bit end share one edge, so count it in.
    assign bit_end      = (div_cnt_q == DIV_LAST) && (sample_cnt_d == SPB);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            hold_q       <= 1'b0;
            hold_full_q  <= 1'b0;
            cur_bit_q    <= 1'b0;
            phase_q      <= '0;
            div_cnt_q    <= '0;
            sample_cnt_q <= '0;
            a_q          <= '0;
            strobe_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    a_q     <= '0;
                    phase_q <= '0;
                    if (hold_full_q) begin
                        cur_bit_q    <= hold_q;
                        hold_full_q  <= 1'b0;
                        div_cnt_q    <= '0;
                        sample_cnt_q <= '0;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    div_cnt_q    <= div_cnt_d;
                    sample_cnt_q <= sample_cnt_d;
                    if (emit) begin
                        a_q      <= sine_val;
                        phase_q  <= phase_d;
                        strobe_q <= 1'b1;
                    end
                    if (bit_end) begin
                        div_cnt_q    <= '0;
                        sample_cnt_q <= '0;
                        if (hold_full_q) begin
                            cur_bit_q   <= hold_q;
                            hold_full_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            phase_q <= '0;
                            if (!emit) a_q <= '0;
                        end
                    end
                end
            endcase
            // Ready is low whenever hold is full, so this never collides with a load above.
            if (accept) begin
                hold_q      <= bit_in;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign bit_ready     = !hold_full_q;
    assign A             = a_q;
    assign sample_strobe = strobe_q;
    assign busy          = (state_q == SEND);
endmodule
